rv32_decoder: RTL and testbench
===============================

Name: rv32_decoder

Overview:
- Decode stage of the RV32IM pipeline with encryption custom opcode.
- Splits a fetched instruction into controller fields, register-file selects and immediates.
- Computes the static-prediction redirect target for the fetch unit.
- Holds one registered prediction flag, which the execute stage uses to check the prediction.

Parameters:
- ADDRESS_BITS, 32, width of pc and target_pc.

Ports:
- clk  in  1  clock; the only state is the flag register.
- rst  in  1  reset, asynchronous, active-high; clears flag.
- pc  in  ADDRESS_BITS  address of the instruction being decoded.
- instruction  in  32  instruction word.
- branch  in  1  execute stage is redirecting or flushing this cycle.
- out_of_loop_i  in  1  loop-exit hint; forces a not-taken prediction for backward branches.
- target_pc  out  ADDRESS_BITS  redirect target for the fetch unit.
- op  out  7  instruction[6:0].
- funct3  out  3  instruction[14:12].
- funct7  out  7  instruction[31:25].
- pc_s_d  out  1  fetch should take target_pc next.
- flag  out  1  registered: the last decoded conditional branch was predicted taken.
- read_sel1  out  5  instruction[19:15].
- read_sel2  out  5  instruction[24:20].
- write_sel  out  5  instruction[11:7].
- wen  out  1  GPR write enable.
- imm32  out  32  sign-extended immediate.
- imm12  out  12  instruction[31:20], raw I-imm or CSR address.

Behaviour:
- All outputs except flag are combinational from instruction, pc, branch and out_of_loop_i.
- op, funct3, funct7, read_sel1, read_sel2, write_sel and imm12 are raw bit slices, valid for every opcode.
- imm32 by opcode, all sign-extended from instruction[31]:
  - I-type (0x13, 0x03, 0x67, 0x73, 0x0B): {instr[31:20]}.
  - S-type (0x23): {instr[31:25], instr[11:7]}.
  - B-type (0x63): {instr[31], instr[7], instr[30:25], instr[11:8], 0}.
  - J-type (0x6F): {instr[31], instr[19:12], instr[20], instr[30:21], 0}.
  - U-type (0x37, 0x17): {instr[31:12], 12'b0}.
  - R-type and others: 0.
- wen = 1 for opcodes 0x33 (incl. M extension), 0x13, 0x03, 0x37, 0x17, 0x6F, 0x67, and 0x73 with funct3 != 0.
- wen is forced to 0 when write_sel == 0.
- wen = 0 for 0x23, 0x63 and custom-0 0x0B; the custom-0 result goes to the accelerator register file through the controller.
- target_pc:
  - JAL: pc + imm32.
  - B-type: pc + imm32.
  - JALR and all other opcodes: pc + 4.
  - Addition is modulo 2^ADDRESS_BITS.
- Prediction rule (pc_s_d):
  - JAL: pc_s_d = 1.
  - B-type with imm32 negative (instr[31] = 1, backward/loop branch) and out_of_loop_i = 0: pc_s_d = 1.
  - Forward branch, JALR and everything else: pc_s_d = 0.
  - branch = 1 forces pc_s_d = 0; an execute redirect has priority over decode prediction.
- flag register:
  - Async reset to 0.
  - On each rising clk edge, flag <= (opcode == 0x63) & pc_s_d.
  - Otherwise flag <= 0 on that edge, so flag is valid for exactly one cycle after the branch is decoded.
  - Reset asserted mid-operation clears flag immediately.
  - flag does not depend on clk while rst = 1.
- Undefined or illegal opcodes: wen = 0, pc_s_d = 0, imm32 = 0, target_pc = pc + 4.

Test Plan:
- Reset, instr = 0x00708093 (addi x1,x1,7) -> op = 0x13, funct3 = 0, read_sel1 = 1, write_sel = 1, imm32 = 7, wen = 1, pc_s_d = 0, flag = 0.
- instr = 0x40208233 (sub x4,x1,x2) -> funct7 = 0x20, read_sel1 = 1, read_sel2 = 2, write_sel = 4, wen = 1.
- instr = 0x0089A423 (sw) -> read_sel1 = 19, read_sel2 = 8, imm32 = 8, wen = 0.
- instr = 0xFC5FF07B at (reserved) -> wen = 0, imm32 = 0, pc_s_d = 0.
- pc = 0, instr = 0x0500036F (jal x6,0x50) -> target_pc = 0x50, pc_s_d = 1, wen = 1, write_sel = 6.
- pc = 0x40, instr = 0xFE000EE3 (beq -4) -> target_pc = 0x3C, pc_s_d = 1, flag = 1 after next clk.
  - Repeat with out_of_loop_i = 1 -> pc_s_d = 0, flag = 0.
  - Repeat with branch = 1 -> pc_s_d = 0, flag = 0.
  - Assert rst with flag = 1 -> flag = 0 immediately.
- instr = 0x00020463 (beq forward 8), pc = 0x10 -> target_pc = 0x18, pc_s_d = 0.
- instr = 0x342D9073 (csrrw x0,0x342,x27) -> imm12 = 0x342, read_sel1 = 27, wen = 0.
- instr = 0x0032408B (custom-0) -> op = 0x0B, write_sel = 1, wen = 0.

Source files
------------

// File: rtl/rv32_decoder.sv
// RV32IM decode stage (custom-0 encryption op): field split, immediates, static branch prediction.
// Combinational outputs except flag, which is registered one cycle; no backpressure -- decodes every cycle.
module rv32_decoder #(
    parameter int ADDRESS_BITS = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [ADDRESS_BITS-1:0] pc,
    input  logic [31:0]             instruction,
    input  logic                    branch,
    input  logic                    out_of_loop_i,
    output logic [ADDRESS_BITS-1:0] target_pc,
    output logic [6:0]              op,
    output logic [2:0]              funct3,
    output logic [6:0]              funct7,
    output logic                    pc_s_d,
    output logic                    flag,
    output logic [4:0]              read_sel1,
    output logic [4:0]              read_sel2,
    output logic [4:0]              write_sel,
    output logic                    wen,
    output logic [31:0]             imm32,
    output logic [11:0]             imm12
);

    localparam logic [6:0] OP_LUI    = 7'h37;
    localparam logic [6:0] OP_AUIPC  = 7'h17;
    localparam logic [6:0] OP_JAL    = 7'h6F;
    localparam logic [6:0] OP_JALR   = 7'h67;
    localparam logic [6:0] OP_BRANCH = 7'h63;
    localparam logic [6:0] OP_LOAD   = 7'h03;
    localparam logic [6:0] OP_STORE  = 7'h23;
    localparam logic [6:0] OP_IMM    = 7'h13;
    localparam logic [6:0] OP_REG    = 7'h33;
    localparam logic [6:0] OP_SYSTEM = 7'h73;
    localparam logic [6:0] OP_CUST0  = 7'h0B;

    typedef enum logic [2:0] {
        IMM_NONE,
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_J,
        IMM_U
    } imm_kind_e;

    imm_kind_e              imm_kind;
    logic                   is_jal;
    logic                   is_bcc;
    logic                   wen_raw;
    logic                   backward;
    logic [31:0]            offset;
    logic [ADDRESS_BITS-1:0] offset_ext;
    logic                   flag_d;
    logic                   flag_q;

    // Raw slices are valid for every opcode; consumers decide which fields matter.
    assign op        = instruction[6:0];
    assign funct3    = instruction[14:12];
    assign funct7    = instruction[31:25];
    assign read_sel1 = instruction[19:15];
    assign read_sel2 = instruction[24:20];
    assign write_sel = instruction[11:7];
    assign imm12     = instruction[31:20];

    always_comb begin
        imm_kind = IMM_NONE;
        is_jal   = 1'b0;
        is_bcc   = 1'b0;
        wen_raw  = 1'b0;
        case (op)
            OP_REG:    wen_raw  = 1'b1;
            OP_IMM,
            OP_LOAD,
            OP_JALR: begin
                imm_kind = IMM_I;
                wen_raw  = 1'b1;
            end
            OP_SYSTEM: begin
                imm_kind = IMM_I;
                wen_raw  = (funct3 != 3'd0);
            end
            OP_CUST0:  imm_kind = IMM_I;
            OP_STORE:  imm_kind = IMM_S;
            OP_BRANCH: begin
                imm_kind = IMM_B;
                is_bcc   = 1'b1;
            end
            OP_JAL: begin
                imm_kind = IMM_J;
                is_jal   = 1'b1;
                wen_raw  = 1'b1;
            end
            OP_LUI,
            OP_AUIPC: begin
                imm_kind = IMM_U;
                wen_raw  = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        imm32 = 32'd0;
        case (imm_kind)
            IMM_I: imm32 = {{20{instruction[31]}}, instruction[31:20]};
            IMM_S: imm32 = {{20{instruction[31]}}, instruction[31:25], instruction[11:7]};
            IMM_B: imm32 = {{19{instruction[31]}}, instruction[31], instruction[7],
                            instruction[30:25], instruction[11:8], 1'b0};
            IMM_J: imm32 = {{11{instruction[31]}}, instruction[31], instruction[19:12],
                            instruction[20], instruction[30:21], 1'b0};
            IMM_U: imm32 = {instruction[31:12], 12'd0};
            default: imm32 = 32'd0;
        endcase
    end

    // x0 is hard-wired zero, so a write to it is never a real write.
    assign wen = wen_raw & (write_sel != 5'd0);

    assign offset = (is_jal | is_bcc) ? imm32 : 32'd4;

    generate
        if (ADDRESS_BITS > 32) begin : g_wide_addr
            assign offset_ext = {{(ADDRESS_BITS-32){offset[31]}}, offset};
        end else begin : g_narrow_addr
            assign offset_ext = offset[ADDRESS_BITS-1:0];
        end
    endgenerate

    assign target_pc = pc + offset_ext;

    // Backward conditional branches are assumed to close loops unless the loop-exit hint says otherwise.
    assign backward = instruction[31];
    assign pc_s_d   = ~branch & (is_jal | (is_bcc & backward & ~out_of_loop_i));

    assign flag_d = is_bcc & pc_s_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flag_q <= 1'b0;
        end else begin
            flag_q <= flag_d;
        end
    end

    assign flag = flag_q;

endmodule

// File: tb/tb_rv32_decoder.sv
// Self-checking bench for rv32_decoder: directed test-plan cases plus randomized decode against a reference model.
module tb_rv32_decoder;

    logic        clk;
    logic        rst;
    logic [31:0] pc;
    logic [31:0] instruction;
    logic        branch;
    logic        out_of_loop_i;
    logic [31:0] target_pc;
    logic [6:0]  op;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic        pc_s_d;
    logic        flag;
    logic [4:0]  read_sel1;
    logic [4:0]  read_sel2;
    logic [4:0]  write_sel;
    logic        wen;
    logic [31:0] imm32;
    logic [11:0] imm12;

    int total;
    int bad;

    rv32_decoder #(.ADDRESS_BITS(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .pc           (pc),
        .instruction  (instruction),
        .branch       (branch),
        .out_of_loop_i(out_of_loop_i),
        .target_pc    (target_pc),
        .op           (op),
        .funct3       (funct3),
        .funct7       (funct7),
        .pc_s_d       (pc_s_d),
        .flag         (flag),
        .read_sel1    (read_sel1),
        .read_sel2    (read_sel2),
        .write_sel    (write_sel),
        .wen          (wen),
        .imm32        (imm32),
        .imm12        (imm12)
    );

    always #5 clk = ~clk;

    // Reference model: immediates built by arithmetic shifts of the word treated as a signed integer.
    function automatic logic [31:0] m_imm(input logic [31:0] ins);
        int          s;
        logic [31:0] r;
        s = int'(ins);
        case (ins[6:0])
            7'h13, 7'h03, 7'h67, 7'h73, 7'h0B: r = 32'(s >>> 20);
            7'h23: r = 32'((s >>> 25) * 32) | 32'(ins[11:7]);
            7'h63: r = 32'((s >>> 31) * 4096) | (32'(ins[7]) << 11) |
                       (32'(ins[30:25]) << 5) | (32'(ins[11:8]) << 1);
            7'h6F: r = 32'((s >>> 31) * 1048576) | (32'(ins[19:12]) << 12) |
                       (32'(ins[20]) << 11) | (32'(ins[30:21]) << 1);
            7'h37, 7'h17: r = ins & 32'hFFFF_F000;
            default: r = 32'd0;
        endcase
        return r;
    endfunction

    function automatic logic m_wen(input logic [31:0] ins);
        logic w;
        case (ins[6:0])
            7'h33, 7'h13, 7'h03, 7'h37, 7'h17, 7'h6F, 7'h67: w = 1'b1;
            7'h73: w = (ins[14:12] != 3'd0);
            default: w = 1'b0;
        endcase
        return w && (ins[11:7] != 5'd0);
    endfunction

    function automatic logic m_pcsd(input logic [31:0] ins, input logic br, input logic ool);
        if (br) return 1'b0;
        if (ins[6:0] == 7'h6F) return 1'b1;
        if (ins[6:0] == 7'h63 && $signed(m_imm(ins)) < 0 && !ool) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] m_target(input logic [31:0] p, input logic [31:0] ins);
        if (ins[6:0] == 7'h6F || ins[6:0] == 7'h63) return p + m_imm(ins);
        return p + 32'd4;
    endfunction

    task automatic drive(input logic [31:0] p, input logic [31:0] ins, input logic br, input logic ool);
        @(negedge clk);
        pc            = p;
        instruction   = ins;
        branch        = br;
        out_of_loop_i = ool;
        #1;
    endtask

    task automatic test_reset;
        drive(32'h0, 32'h00708093, 1'b0, 1'b0);
        total++; if (flag !== 1'b0) begin bad++; $display("FAIL reset_flag got=%0h exp=0", flag); end
        total++; if (op !== 7'h13) begin bad++; $display("FAIL addi_op got=%0h exp=13", op); end
        total++; if (funct3 !== 3'd0) begin bad++; $display("FAIL addi_funct3 got=%0h exp=0", funct3); end
        total++; if (read_sel1 !== 5'd1) begin bad++; $display("FAIL addi_rs1 got=%0d exp=1", read_sel1); end
        total++; if (write_sel !== 5'd1) begin bad++; $display("FAIL addi_rd got=%0d exp=1", write_sel); end
        total++; if (imm32 !== 32'd7) begin bad++; $display("FAIL addi_imm got=%0h exp=7", imm32); end
        total++; if (wen !== 1'b1) begin bad++; $display("FAIL addi_wen got=%0h exp=1", wen); end
        total++; if (pc_s_d !== 1'b0) begin bad++; $display("FAIL addi_pcsd got=%0h exp=0", pc_s_d); end
        // A predicted-taken branch must not set flag while reset is held.
        drive(32'h40, 32'hFE000EE3, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        total++; if (flag !== 1'b0) begin bad++; $display("FAIL reset_hold_flag got=%0h exp=0", flag); end
        rst = 1'b0;
    endtask

    task automatic test_rtype;
        drive(32'h0, 32'h40208233, 1'b0, 1'b0);
        total++; if (funct7 !== 7'h20) begin bad++; $display("FAIL sub_funct7 got=%0h exp=20", funct7); end
        total++; if (read_sel1 !== 5'd1) begin bad++; $display("FAIL sub_rs1 got=%0d exp=1", read_sel1); end
        total++; if (read_sel2 !== 5'd2) begin bad++; $display("FAIL sub_rs2 got=%0d exp=2", read_sel2); end
        total++; if (write_sel !== 5'd4) begin bad++; $display("FAIL sub_rd got=%0d exp=4", write_sel); end
        total++; if (wen !== 1'b1) begin bad++; $display("FAIL sub_wen got=%0h exp=1", wen); end
        total++; if (imm32 !== 32'd0) begin bad++; $display("FAIL sub_imm got=%0h exp=0", imm32); end
    endtask

    task automatic test_store;
        drive(32'h0, 32'h0089A423, 1'b0, 1'b0);
        total++; if (read_sel1 !== 5'd19) begin bad++; $display("FAIL sw_rs1 got=%0d exp=19", read_sel1); end
        total++; if (read_sel2 !== 5'd8) begin bad++; $display("FAIL sw_rs2 got=%0d exp=8", read_sel2); end
        total++; if (imm32 !== 32'd8) begin bad++; $display("FAIL sw_imm got=%0h exp=8", imm32); end
        total++; if (wen !== 1'b0) begin bad++; $display("FAIL sw_wen got=%0h exp=0", wen); end
    endtask

    task automatic test_reserved;
        drive(32'h100, 32'hFC5FF07B, 1'b0, 1'b0);
        total++; if (wen !== 1'b0) begin bad++; $display("FAIL rsv_wen got=%0h exp=0", wen); end
        total++; if (imm32 !== 32'd0) begin bad++; $display("FAIL rsv_imm got=%0h exp=0", imm32); end
        total++; if (pc_s_d !== 1'b0) begin bad++; $display("FAIL rsv_pcsd got=%0h exp=0", pc_s_d); end
        total++; if (target_pc !== 32'h104) begin bad++; $display("FAIL rsv_target got=%0h exp=104", target_pc); end
    endtask

    task automatic test_jal;
        drive(32'h0, 32'h0500036F, 1'b0, 1'b0);
        total++; if (target_pc !== 32'h50) begin bad++; $display("FAIL jal_target got=%0h exp=50", target_pc); end
        total++; if (pc_s_d !== 1'b1) begin bad++; $display("FAIL jal_pcsd got=%0h exp=1", pc_s_d); end
        total++; if (wen !== 1'b1) begin bad++; $display("FAIL jal_wen got=%0h exp=1", wen); end
        total++; if (write_sel !== 5'd6) begin bad++; $display("FAIL jal_rd got=%0d exp=6", write_sel); end
        @(posedge clk); #1;
        total++; if (flag !== 1'b0) begin bad++; $display("FAIL jal_flag got=%0h exp=0", flag); end
    endtask

    task automatic test_backward_branch;
        drive(32'h40, 32'hFE000EE3, 1'b0, 1'b0);
        total++; if (target_pc !== 32'h3C) begin bad++; $display("FAIL bwd_target got=%0h exp=3c", target_pc); end
        total++; if (pc_s_d !== 1'b1) begin bad++; $display("FAIL bwd_pcsd got=%0h exp=1", pc_s_d); end
        @(posedge clk); #1;
        total++; if (flag !== 1'b1) begin bad++; $display("FAIL bwd_flag got=%0h exp=1", flag); end
        drive(32'h40, 32'hFE000EE3, 1'b0, 1'b1);
        total++; if (pc_s_d !== 1'b0) begin bad++; $display("FAIL bwd_ool_pcsd got=%0h exp=0", pc_s_d); end
        @(posedge clk); #1;
        total++; if (flag !== 1'b0) begin bad++; $display("FAIL bwd_ool_flag got=%0h exp=0", flag); end
        drive(32'h40, 32'hFE000EE3, 1'b1, 1'b0);
        total++; if (pc_s_d !== 1'b0) begin bad++; $display("FAIL bwd_br_pcsd got=%0h exp=0", pc_s_d); end
        @(posedge clk); #1;
        total++; if (flag !== 1'b0) begin bad++; $display("FAIL bwd_br_flag got=%0h exp=0", flag); end
        drive(32'h40, 32'hFE000EE3, 1'b0, 1'b0);
        @(posedge clk); #1;
        total++; if (flag !== 1'b1) begin bad++; $display("FAIL bwd_preset_flag got=%0h exp=1", flag); end
        #2 rst = 1'b1;
        #1;
        total++; if (flag !== 1'b0) begin bad++; $display("FAIL async_rst_flag got=%0h exp=0", flag); end
        rst = 1'b0;
    endtask

    task automatic test_forward_branch;
        drive(32'h10, 32'h00020463, 1'b0, 1'b0);
        total++; if (target_pc !== 32'h18) begin bad++; $display("FAIL fwd_target got=%0h exp=18", target_pc); end
        total++; if (pc_s_d !== 1'b0) begin bad++; $display("FAIL fwd_pcsd got=%0h exp=0", pc_s_d); end
        total++; if (wen !== 1'b0) begin bad++; $display("FAIL fwd_wen got=%0h exp=0", wen); end
    endtask

    task automatic test_csr;
        drive(32'h0, 32'h342D9073, 1'b0, 1'b0);
        total++; if (imm12 !== 12'h342) begin bad++; $display("FAIL csr_imm12 got=%0h exp=342", imm12); end
        total++; if (read_sel1 !== 5'd27) begin bad++; $display("FAIL csr_rs1 got=%0d exp=27", read_sel1); end
        total++; if (wen !== 1'b0) begin bad++; $display("FAIL csr_wen got=%0h exp=0", wen); end
    endtask

    task automatic test_custom;
        drive(32'h0, 32'h0032408B, 1'b0, 1'b0);
        total++; if (op !== 7'h0B) begin bad++; $display("FAIL cust_op got=%0h exp=0b", op); end
        total++; if (write_sel !== 5'd1) begin bad++; $display("FAIL cust_rd got=%0d exp=1", write_sel); end
        total++; if (wen !== 1'b0) begin bad++; $display("FAIL cust_wen got=%0h exp=0", wen); end
    endtask

    task automatic test_back_to_back;
        // flag is one cycle wide: a taken branch followed by an addi clears it on the next edge.
        drive(32'h200, 32'hFE000EE3, 1'b0, 1'b0);
        @(posedge clk); #1;
        total++; if (flag !== 1'b1) begin bad++; $display("FAIL b2b_flag1 got=%0h exp=1", flag); end
        drive(32'h204, 32'h00708093, 1'b0, 1'b0);
        @(posedge clk); #1;
        total++; if (flag !== 1'b0) begin bad++; $display("FAIL b2b_flag2 got=%0h exp=0", flag); end
    endtask

    task automatic test_random;
        logic [6:0]  ops [13];
        logic [31:0] r;
        logic [31:0] p;
        logic [31:0] ins;
        logic        br;
        logic        ool;
        logic        e_pcsd;
        ops = '{7'h13, 7'h03, 7'h67, 7'h73, 7'h0B, 7'h23, 7'h63, 7'h63, 7'h6F, 7'h37, 7'h17, 7'h33, 7'h7F};
        for (int n = 0; n < 400; n++) begin
            r   = $urandom();
            ins = {r[31:7], ops[$urandom_range(12)]};
            if (n % 7 == 0) ins[6:0] = 7'($urandom());
            p   = $urandom() & 32'hFFFF_FFFC;
            br  = ($urandom_range(3) == 0);
            ool = ($urandom_range(3) == 0);
            drive(p, ins, br, ool);
            e_pcsd = m_pcsd(ins, br, ool);
            total++; if (imm32 !== m_imm(ins)) begin bad++; $display("FAIL rnd_imm ins=%08h got=%08h exp=%08h", ins, imm32, m_imm(ins)); end
            total++; if (wen !== m_wen(ins)) begin bad++; $display("FAIL rnd_wen ins=%08h got=%0h exp=%0h", ins, wen, m_wen(ins)); end
            total++; if (pc_s_d !== e_pcsd) begin bad++; $display("FAIL rnd_pcsd ins=%08h got=%0h exp=%0h", ins, pc_s_d, e_pcsd); end
            total++; if (target_pc !== m_target(p, ins)) begin bad++; $display("FAIL rnd_target ins=%08h pc=%08h got=%08h exp=%08h", ins, p, target_pc, m_target(p, ins)); end
            total++; if ({op, funct3, funct7, read_sel1, read_sel2, write_sel, imm12} !==
                         {ins[6:0], ins[14:12], ins[31:25], ins[19:15], ins[24:20], ins[11:7], ins[31:20]})
                     begin bad++; $display("FAIL rnd_fields ins=%08h got_op=%0h got_rd=%0d", ins, op, write_sel); end
            @(posedge clk); #1;
            total++; if (flag !== (ins[6:0] == 7'h63 && e_pcsd)) begin bad++; $display("FAIL rnd_flag ins=%08h got=%0h exp=%0h", ins, flag, (ins[6:0] == 7'h63 && e_pcsd)); end
        end
    endtask

    initial begin
        total         = 0;
        bad           = 0;
        clk           = 1'b0;
        rst           = 1'b1;
        pc            = 32'h0;
        instruction   = 32'h0;
        branch        = 1'b0;
        out_of_loop_i = 1'b0;
        test_reset();
        test_rtype();
        test_store();
        test_reserved();
        test_jal();
        test_backward_branch();
        test_forward_branch();
        test_csr();
        test_custom();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
